// File: rtl/d_scheduler.sv
// d_scheduler: sequences one SD multi-block job (receive, cipher each RAM block, send with card-busy pacing).
// Define D_SCHED_WATCHDOG_EN to abort any wait state that lasts TIMEOUT cycles.
module d_scheduler #(
    parameter int RAM_BLOCKS = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          itrans_start,
    output logic                          ocmd_busy,
    output logic                          odone,
    output logic                          oerror,
    output logic [1:0]                    oerr_code,
    output logic                          odrv_start,
    output logic                          odrv_rst,
    input  logic                          idrv_read_done,
    input  logic                          idrv_write_done,
    input  logic                          idrv_check_status,
    input  logic                          icard_ready,
    output logic                          oproc_start,
    output logic [$clog2(RAM_BLOCKS)-1:0] oproc_sel,
    input  logic                          iproc_done
);
    localparam int BW = $clog2(RAM_BLOCKS);
    localparam logic [BW-1:0] LAST = BW'(RAM_BLOCKS - 1);

    if (RAM_BLOCKS < 2 || (RAM_BLOCKS & (RAM_BLOCKS - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("d_scheduler: RAM_BLOCKS must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_WAIT, PROC_START, PROC_WAIT,
        TX_START, TX_WAIT, BUSY_WAIT, DONE, ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   blk_q, blk_d;
    logic [BW-1:0]   sel_q, sel_d;
    logic [1:0]      err_q, err_d;
    logic            first_q;
    logic            busy_q, done_q, error_q, drv_rst_q;
    logic            drv_start_q, drv_start_d;
    logic            proc_start_q, proc_start_d;
    logic            wd_hit;

`ifdef D_SCHED_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          waiting;

    assign waiting = state_q inside {RX_WAIT, PROC_WAIT, TX_WAIT, BUSY_WAIT};
    assign wd_d    = (state_d != state_q) ? '0 : waiting ? wd_q + 1'b1 : wd_q;
    assign wd_hit  = waiting && (wd_q == WW'(TIMEOUT - 1));

    always_ff @(posedge iclk or posedge irst) begin
        if (irst)
            wd_q <= '0;
        else
            wd_q <= wd_d;
    end
`else
    assign wd_hit = 1'b0;
`endif

    // Exit conditions are tested before wd_hit so a coinciding timeout loses.
    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        err_d        = err_q;
        sel_d        = sel_q;
        drv_start_d  = 1'b0;
        proc_start_d = 1'b0;
        case (state_q)
            IDLE: if (itrans_start) begin
                state_d = RX_START;
                blk_d   = '0;
                err_d   = 2'b00;
            end
            RX_START: begin
                drv_start_d = 1'b1;
                state_d     = RX_WAIT;
            end
            RX_WAIT: begin
                if (idrv_read_done)
                    state_d = PROC_START;
                else if (idrv_write_done && !first_q) begin
                    state_d = ABORT;
                    err_d   = 2'b01;
                end else if (wd_hit) begin
                    state_d = ABORT;
                    err_d   = 2'b10;
                end
            end
            PROC_START: begin
                proc_start_d = 1'b1;
                sel_d        = blk_q;
                state_d      = PROC_WAIT;
            end
            PROC_WAIT: begin
                if (iproc_done) begin
                    blk_d   = blk_q + 1'b1;
                    state_d = (blk_q == LAST) ? TX_START : PROC_START;
                end else if (wd_hit) begin
                    state_d = ABORT;
                    err_d   = 2'b10;
                end
            end
            TX_START: begin
                drv_start_d = 1'b1;
                state_d     = TX_WAIT;
            end
            TX_WAIT: begin
                if (idrv_check_status)
                    state_d = BUSY_WAIT;
                else if (wd_hit) begin
                    state_d = ABORT;
                    err_d   = 2'b10;
                end
            end
            // The final start pulse returns the driver to idle.
            BUSY_WAIT: begin
                if (icard_ready) begin
                    blk_d       = blk_q + 1'b1;
                    drv_start_d = (blk_q == LAST);
                    state_d     = (blk_q == LAST) ? DONE : TX_START;
                end else if (wd_hit) begin
                    state_d = ABORT;
                    err_d   = 2'b10;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q      <= IDLE;
            blk_q        <= '0;
            sel_q        <= '0;
            err_q        <= 2'b00;
            first_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            drv_rst_q    <= 1'b0;
            drv_start_q  <= 1'b0;
            proc_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            sel_q        <= sel_d;
            err_q        <= err_d;
            first_q      <= (state_q == RX_START);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ABORT);
            drv_rst_q    <= (state_d == ABORT) || (state_q == ABORT);
            drv_start_q  <= drv_start_d;
            proc_start_q <= proc_start_d;
        end
    end

    assign ocmd_busy   = busy_q;
    assign odone       = done_q;
    assign oerror      = error_q;
    assign oerr_code   = err_q;
    assign odrv_start  = drv_start_q;
    assign odrv_rst    = drv_rst_q;
    assign oproc_start = proc_start_q;
    assign oproc_sel   = sel_q;
endmodule
